// File: rtl/wrf_pkg.sv
`default_nettype none
// wrf_pkg: fabric address classes, sink FSM states and the layout of one buffered word.
// Rev 1.0
package wrf_pkg;

  localparam logic [1:0] c_WRF_DATA   = 2'd0;
  localparam logic [1:0] c_WRF_OOB    = 2'd1;
  localparam logic [1:0] c_WRF_STATUS = 2'd2;
  localparam logic [1:0] c_WRF_USER   = 2'd3;

  localparam int c_ENTRY_W = 23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_OOB  = 2'd3
  } wrf_state_t;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  typ;
    logic [1:0]  sel;
    logic        sof;
    logic        eof;
    logic        error;
  } wrf_entry_t;

endpackage
`default_nettype wire

// File: rtl/wrf_sink_fifo.sv
`default_nettype none
// wrf_sink_fifo: synchronous show-ahead FIFO of packed sink entries with occupancy count.
// Rev 1.0
module wrf_sink_fifo
  import wrf_pkg::*;
#(
  parameter int g_fifo_depth = 16,
  localparam int c_AW = $clog2(g_fifo_depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 push,
  input  logic [c_ENTRY_W-1:0] din,
  input  logic                 pop,
  output logic [c_ENTRY_W-1:0] dout,
  output logic                 empty,
  output logic [c_AW:0]        count
);

  logic [c_ENTRY_W-1:0] mem [g_fifo_depth];
  logic [c_AW-1:0]      wr_ptr;
  logic [c_AW-1:0]      rd_ptr;
  logic                 do_pop;
  logic                 full;

  assign empty  = (count == '0);
  assign full   = (count == (c_AW+1)'(g_fifo_depth));
  assign do_pop = pop && !empty;
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{c_AW{1'b0}}, push} - {{c_AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= din;
  end

  // The upstream stall margin guarantees a push never meets a full FIFO.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i) !(push && full));

endmodule
`default_nettype wire

// File: rtl/wrf_fabric_sink.sv
`default_nettype none
// wrf_fabric_sink: pipelined Wishbone fabric sink that frames, checks and buffers
// switch-core output words onto a valid/ready stream. Rev 1.0
module wrf_fabric_sink
  import wrf_pkg::*;
#(
  parameter int g_wb_data_width = 16,
  parameter int g_wb_addr_width = 2,
  parameter int g_wb_sel_width  = 2,
  parameter int g_fifo_depth    = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [g_wb_data_width-1:0] snk_dat_i,
  input  logic [g_wb_addr_width-1:0] snk_adr_i,
  input  logic [g_wb_sel_width-1:0]  snk_sel_i,
  input  logic                       snk_cyc_i,
  input  logic                       snk_stb_i,
  input  logic                       snk_we_i,
  output logic                       snk_stall_o,
  output logic                       snk_ack_o,
  output logic                       snk_err_o,
  output logic                       snk_rty_o,
  output logic [g_wb_data_width-1:0] dout_o,
  output logic [1:0]                 dout_type_o,
  output logic [1:0]                 dout_sel_o,
  output logic                       dout_sof_o,
  output logic                       dout_eof_o,
  output logic                       dout_error_o,
  output logic                       dout_valid_o,
  input  logic                       dout_ready_i,
  output logic [31:0]                frame_cnt_o,
  output logic [31:0]                err_cnt_o
);

  localparam int c_AW = $clog2(g_fifo_depth);

  wrf_state_t state, state_nxt, eff_state;
  logic       bad, bad_nxt, set_bad;
  logic       stall, ack, err;
  logic       hold_valid;
  wrf_entry_t hold, push_ent, head;
  logic       beat, beat_wr, push, push_eof;
  logic       fifo_empty;
  logic [c_ENTRY_W-1:0] head_bits;
  logic [c_AW:0]        fifo_count;

  assign beat     = snk_cyc_i & snk_stb_i & ~stall;
  assign beat_wr  = beat & snk_we_i;
  assign push_eof = ~snk_cyc_i & hold_valid;
  assign push     = (beat_wr & hold_valid) | push_eof;

  // A beat may arrive in the same cycle cyc rises, so IDLE is classified as HDR.
  assign eff_state = (state == ST_IDLE) ? ST_HDR : state;

  always_comb begin
    state_nxt = state;
    set_bad   = 1'b0;
    if (!snk_cyc_i) begin
      state_nxt = ST_IDLE;
    end else begin
      state_nxt = eff_state;
      if (beat_wr) begin
        case (eff_state)
          ST_HDR: begin
            set_bad   = (snk_adr_i != c_WRF_STATUS);
            state_nxt = (snk_adr_i == c_WRF_OOB) ? ST_OOB : ST_DATA;
          end
          ST_DATA: begin
            if (snk_adr_i == c_WRF_STATUS)   set_bad   = 1'b1;
            else if (snk_adr_i == c_WRF_OOB) state_nxt = ST_OOB;
          end
          ST_OOB: set_bad = (snk_adr_i == c_WRF_DATA) || (snk_adr_i == c_WRF_STATUS);
          default: ;
        endcase
      end
    end
  end

  assign bad_nxt = ((state == ST_IDLE) ? 1'b0 : bad) | set_bad;

  always_comb begin
    push_ent       = hold;
    push_ent.eof   = push_eof;
    push_ent.error = push_eof & bad;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      bad         <= 1'b0;
      stall       <= 1'b0;
      ack         <= 1'b0;
      err         <= 1'b0;
      hold_valid  <= 1'b0;
      hold        <= '0;
      frame_cnt_o <= '0;
      err_cnt_o   <= '0;
    end else begin
      state <= state_nxt;
      bad   <= bad_nxt;
      // Two free slots cover the beat already in flight plus the held word.
      stall <= (fifo_count >= (c_AW+1)'(g_fifo_depth - 2));
      ack   <= beat_wr;
      err   <= beat & ~snk_we_i;
      if (beat_wr) begin
        hold.data  <= snk_dat_i;
        hold.typ   <= snk_adr_i;
        hold.sel   <= snk_sel_i;
        hold.sof   <= ~hold_valid;
        hold_valid <= 1'b1;
      end else if (push_eof) begin
        hold_valid <= 1'b0;
      end
      if (push_eof) begin
        frame_cnt_o <= frame_cnt_o + 32'd1;
        if (bad) err_cnt_o <= err_cnt_o + 32'd1;
      end
    end
  end

  wrf_sink_fifo #(
    .g_fifo_depth(g_fifo_depth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .push   (push),
    .din    (push_ent),
    .pop    (dout_valid_o & dout_ready_i),
    .dout   (head_bits),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign head         = wrf_entry_t'(head_bits);
  assign dout_valid_o = ~fifo_empty;
  assign dout_o       = dout_valid_o ? head.data  : '0;
  assign dout_type_o  = dout_valid_o ? head.typ   : '0;
  assign dout_sel_o   = dout_valid_o ? head.sel   : '0;
  assign dout_sof_o   = dout_valid_o & head.sof;
  assign dout_eof_o   = dout_valid_o & head.eof;
  assign dout_error_o = dout_valid_o & head.error;

  assign snk_stall_o = stall;
  assign snk_ack_o   = ack;
  assign snk_err_o   = err;
  assign snk_rty_o   = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_wrf_fabric_sink.sv
`default_nettype none
// tb_wrf_fabric_sink: scoreboard bench for the fabric sink.
module tb_wrf_fabric_sink;
  import wrf_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cyc, stb, we, ready;
  logic [15:0] dat;
  logic [1:0]  adr, sel;
  logic        stall_o, ack_o, err_o, rty_o;
  logic [15:0] dout;
  logic [1:0]  dtype, dsel;
  logic        sof, eof, derr, valid;
  logic [31:0] frame_cnt, err_cnt;

  wrf_fabric_sink dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .snk_dat_i(dat), .snk_adr_i(adr), .snk_sel_i(sel),
    .snk_cyc_i(cyc), .snk_stb_i(stb), .snk_we_i(we),
    .snk_stall_o(stall_o), .snk_ack_o(ack_o), .snk_err_o(err_o), .snk_rty_o(rty_o),
    .dout_o(dout), .dout_type_o(dtype), .dout_sel_o(dsel),
    .dout_sof_o(sof), .dout_eof_o(eof), .dout_error_o(derr),
    .dout_valid_o(valid), .dout_ready_i(ready),
    .frame_cnt_o(frame_cnt), .err_cnt_o(err_cnt)
  );

  typedef struct {
    bit          we;
    logic [1:0]  adr;
    logic [15:0] dat;
    logic [1:0]  sel;
  } beat_t;

  beat_t       frame[$];
  logic [22:0] sb[$];
  logic [22:0] sb_exp;
  bit          exp_ack = 1'b0, exp_err = 1'b0;
  int          n_chk = 0, n_pass = 0;
  int          n_acc = 0, stall_at = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic add(input bit w, input logic [1:0] a, input logic [15:0] d, input logic [1:0] s);
    beat_t b;
    b.we = w; b.adr = a; b.dat = d; b.sel = s;
    frame.push_back(b);
  endtask

  // Handshake and output monitor; everything is sampled on the falling edge.
  always @(negedge clk) begin
    if (ack_o || err_o || exp_ack || exp_err) begin
      check("ack", 32'(ack_o), 32'(exp_ack));
      check("err", 32'(err_o), 32'(exp_err));
    end
    exp_ack = cyc && stb && we && !stall_o && rst_n;
    exp_err = cyc && stb && !we && !stall_o && rst_n;
    if (valid && ready) begin
      if (sb.size() == 0) check("extra_word", 32'd1, 32'd0);
      else begin
        sb_exp = sb.pop_front();
        check("word", {9'd0, dout, dtype, dsel, sof, eof, derr}, {9'd0, sb_exp});
      end
    end
  end

  task automatic run_frame(input int gap, input bit abort);
    int  mode, last, waitc;
    bit  bad, first, acc;
    if (!abort) begin
      mode = 0; bad = 1'b0; last = -1;
      foreach (frame[i]) begin
        if (!frame[i].we) continue;
        last = i;
        case (mode)
          0: begin
            if (frame[i].adr != c_WRF_STATUS) bad = 1'b1;
            mode = (frame[i].adr == c_WRF_OOB) ? 2 : 1;
          end
          1: begin
            if (frame[i].adr == c_WRF_STATUS) bad = 1'b1;
            if (frame[i].adr == c_WRF_OOB) mode = 2;
          end
          default: if (frame[i].adr == c_WRF_DATA || frame[i].adr == c_WRF_STATUS) bad = 1'b1;
        endcase
      end
      first = 1'b1;
      foreach (frame[i]) begin
        if (!frame[i].we) continue;
        sb.push_back({frame[i].dat, frame[i].adr, frame[i].sel, first, i == last, (i == last) && bad});
        first = 1'b0;
      end
    end
    cyc = 1'b1;
    foreach (frame[i]) begin
      stb = 1'b1; we = frame[i].we; adr = frame[i].adr; dat = frame[i].dat; sel = frame[i].sel;
      acc = 1'b0; waitc = 0;
      while (!acc && waitc < 200) begin
        @(negedge clk);
        acc = !stall_o;
        if (!acc && stall_at < 0) stall_at = n_acc;
        @(posedge clk); #1;
        waitc++;
      end
      if (!acc) begin
        check("beat_timeout", 32'd1, 32'd0);
        break;
      end
      n_acc++;
    end
    stb = 1'b0; we = 1'b0;
    if (abort) begin
      check("pre_rst_valid", 32'(valid), 32'd1);
      rst_n = 1'b0; cyc = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
    end else begin
      cyc = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    frame.delete();
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb.size() != 0 || valid) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 300) check("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; dat = '0; sel = '0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_ack", {30'd0, ack_o, err_o}, 32'd0);
    check("rst_rty", 32'(rty_o), 32'd0);
    check("rst_dout", {16'd0, dout}, 32'd0);
    check("rst_frame_cnt", frame_cnt, 32'd0);
    check("rst_err_cnt", err_cnt, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Well-formed status/data/data/OOB frame
    add(1, c_WRF_STATUS, 16'h1234, 2'b11); add(1, c_WRF_DATA, 16'hAAAA, 2'b11);
    add(1, c_WRF_DATA, 16'hBBBB, 2'b11);   add(1, c_WRF_OOB, 16'h0001, 2'b01);
    run_frame(1, 0);
    wait_drain();
    check("a_frame_cnt", frame_cnt, 32'd1);
    check("a_err_cnt", err_cnt, 32'd0);

    // Data before status
    add(1, c_WRF_DATA, 16'h5555, 2'b10); add(1, c_WRF_STATUS, 16'h0002, 2'b11);
    run_frame(1, 0);
    wait_drain();
    check("b_frame_cnt", frame_cnt, 32'd2);
    check("b_err_cnt", err_cnt, 32'd1);

    // 20 words against a blocked output
    ready = 1'b0; stall_at = -1; n_acc = 0;
    add(1, c_WRF_STATUS, 16'h0100, 2'b11);
    for (int k = 1; k < 20; k++) add(1, c_WRF_DATA, 16'h0100 + 16'(k), 2'(k));
    fork
      run_frame(1, 0);
      begin
        repeat (30) @(posedge clk);
        #1;
        check("c_held_valid", 32'(valid), 32'd1);
        check("c_held_head", {16'd0, dout}, 32'h0100);
        ready = 1'b1;
      end
    join
    wait_drain();
    check("c_stall_after", 32'(stall_at), 32'd16);
    check("c_frame_cnt", frame_cnt, 32'd3);

    // Read beat inside a frame
    add(1, c_WRF_STATUS, 16'h0300, 2'b11); add(1, c_WRF_DATA, 16'h1111, 2'b11);
    add(0, c_WRF_DATA, 16'hDEAD, 2'b11);   add(1, c_WRF_DATA, 16'h2222, 2'b01);
    run_frame(1, 0);
    wait_drain();
    check("d_frame_cnt", frame_cnt, 32'd4);
    check("d_err_cnt", err_cnt, 32'd1);

    // cyc pulse without strobes
    cyc = 1'b1;
    repeat (3) @(posedge clk);
    #1 cyc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("e_valid", 32'(valid), 32'd0);
    check("e_frame_cnt", frame_cnt, 32'd4);

    // Back-to-back frames, one idle cycle between them
    add(1, c_WRF_STATUS, 16'h0500, 2'b11); add(1, c_WRF_USER, 16'h0501, 2'b11);
    run_frame(1, 0);
    add(1, c_WRF_STATUS, 16'h0600, 2'b11); add(1, c_WRF_OOB, 16'h0601, 2'b11);
    add(1, c_WRF_DATA, 16'h0602, 2'b11);
    run_frame(1, 0);
    wait_drain();
    check("f_frame_cnt", frame_cnt, 32'd6);
    check("f_err_cnt", err_cnt, 32'd2);

    // Reset in the middle of a frame
    ready = 1'b0;
    add(1, c_WRF_STATUS, 16'h0F00, 2'b11); add(1, c_WRF_DATA, 16'h0F01, 2'b11);
    add(1, c_WRF_DATA, 16'h0F02, 2'b11);
    run_frame(1, 1);
    check("g_valid", 32'(valid), 32'd0);
    check("g_stall", 32'(stall_o), 32'd0);
    check("g_dout", {16'd0, dout}, 32'd0);
    check("g_frame_cnt", frame_cnt, 32'd0);
    check("g_err_cnt", err_cnt, 32'd0);
    ready = 1'b1;
    add(1, c_WRF_STATUS, 16'h0700, 2'b11); add(1, c_WRF_OOB, 16'h0701, 2'b10);
    add(1, c_WRF_USER, 16'h0702, 2'b01);
    run_frame(1, 0);
    wait_drain();
    check("g2_frame_cnt", frame_cnt, 32'd1);
    check("g2_err_cnt", err_cnt, 32'd0);

    // Single-word frame: valid two cycles after the beat
    add(1, c_WRF_STATUS, 16'h0800, 2'b11);
    run_frame(1, 0);
    check("h_single_valid", 32'(valid), 32'd1);
    wait_drain();
    check("h_frame_cnt", frame_cnt, 32'd2);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
